// File: rtl/program_loader.sv
// program_loader: streams bytes from a valid/ready source into program memory.
// Optional trailing checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] A_ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK = 2'd3,
`endif
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] len_q;

  logic load_take;
  logic load_last;
  logic kick;

  logic ready_d;
  logic hold_d;
  logic busy_d;
  logic done_d;

  // in_ready is registered and only high in LOAD/CHECK,
  // so it qualifies every transfer.
  assign kick      = (state == IDLE) && start;
  assign load_take = (state == LOAD) && in_valid && in_ready;
  assign load_last = load_take &&
                     (count_q == (len_q - A_ONE));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_next;
  logic              chk_take;
  logic              chk_ok;

  assign chk_take = (state == CHECK) && in_valid && in_ready;
  assign sum_next = sum_q + in_data;
  assign chk_ok   = (sum_next == '0);
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          next_state = (len == '0) ? CHECK : LOAD;
`else
          next_state = (len == '0) ? DONE : LOAD;
`endif
        end
      end
      LOAD: begin
        if (load_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (chk_take) begin
          next_state = chk_ok ? DONE : IDLE;
        end
      end
`endif
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state; registered below
  always_comb begin
    ready_d = (next_state == LOAD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ready_d = ready_d || (next_state == CHECK);
`endif
    hold_d = ready_d;
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
  end

  // Registered control outputs and write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready <= 1'b0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      in_ready <= ready_d;
      cpu_hold <= hold_d;
      busy     <= busy_d;
      done     <= done_d;
      mem_we   <= load_take;
    end
  end

  // Address/count/length bookkeeping and write port data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      count_q  <= '0;
      len_q    <= '0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (kick) begin
      addr_q  <= start_addr;
      count_q <= '0;
      len_q   <= len;
    end else if (load_take) begin
      addr_q   <= addr_q + A_ONE;
      count_q  <= count_q + A_ONE;
      mem_addr <= addr_q;
      mem_data <= in_data;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running byte sum and sticky checksum error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
      error <= 1'b0;
    end else if (kick) begin
      sum_q <= '0;
      error <= 1'b0;
    end else if (load_take) begin
      sum_q <= sum_next;
    end else if (chk_take && !chk_ok) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
